// File: rtl/paddle_collision_ctrl.sv
// Upstream controller for the ball-movement stage: frame tick, paddle collision,
// rally/lives bookkeeping and the serve/play/game-over sequencing FSM.
module paddle_collision_ctrl #(
   parameter int TICK_DIV      = 833333,
   parameter int PADDLE_X      = 210,
   parameter int MISS_X        = 225,
   parameter int PADDLE_HEIGHT = 40,
   parameter int BALL_SIZE     = 4,
   parameter int SERVE_DELAY   = 60,
   parameter int LIVES         = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] paddle_y,
   input  logic [7:0] ball_x,
   input  logic [8:0] ball_y,
   input  logic       ball_dir,
   output logic       ball_enable,
   output logic       ball_reset,
   output logic       x_dir_change,
   output logic [1:0] y_dir_change,
   output logic [7:0] rally_count,
   output logic [3:0] lives,
   output logic       game_over,
   output logic [2:0] state
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SERVE_LAST = SW'((SERVE_DELAY == 0) ? 0 : SERVE_DELAY - 1);

   localparam logic [9:0] PADDLE_X10  = 10'(PADDLE_X);
   localparam logic [9:0] MISS_X10    = 10'(MISS_X);
   localparam logic [9:0] PADDLE_H10  = 10'(PADDLE_HEIGHT);
   localparam logic [9:0] PADDLE_HH10 = 10'(PADDLE_HEIGHT / 2);
   localparam logic [9:0] BALL_S10    = 10'(BALL_SIZE);
   localparam logic [9:0] BALL_HS10   = 10'(BALL_SIZE / 2);
   localparam logic [3:0] LIVES_INIT  = 4'(LIVES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      MISS      = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_tickCount;
   logic [SW-1:0] r_serveCount;
   logic          r_ballEnable;
   logic          r_ballReset;
   logic          r_xDir;
   logic [1:0]    r_yDir;
   logic [7:0]    r_rally;
   logic [3:0]    r_lives;
   logic          r_gameOver;

   logic       w_tick;
   logic [9:0] w_ballX;
   logic [9:0] w_ballY;
   logic [9:0] w_paddleY;
   logic       w_hit;
   logic       w_topHalf;
   logic       w_miss;
   logic       w_xNext;

   // Everything is widened to 10 bits so the sums below can never wrap.
   assign w_tick    = (r_tickCount == TICK_LAST);
   assign w_ballX   = {2'b00, ball_x};
   assign w_ballY   = {1'b0, ball_y};
   assign w_paddleY = {1'b0, paddle_y};

   assign w_hit = ball_dir
                  && (w_ballX >= PADDLE_X10)
                  && (w_ballX < MISS_X10)
                  && ((w_ballY + BALL_S10) > w_paddleY)
                  && (w_ballY < (w_paddleY + PADDLE_H10));

   assign w_topHalf = (w_ballY + BALL_HS10) < (w_paddleY + PADDLE_HH10);
   assign w_miss    = ball_dir && (w_ballX >= MISS_X10);
   assign w_xNext   = w_hit && (r_state == PLAY);

   // Free-running frame divider, independent of the game state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tickCount <= '0;
      end else if (w_tick) begin
         r_tickCount <= '0;
      end else begin
         r_tickCount <= r_tickCount + 1'b1;
      end
   end

   // Game FSM with all outputs registered; the start handling in the case
   // statement deliberately overrides the rally increment above it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_serveCount <= '0;
         r_ballEnable <= 1'b0;
         r_ballReset  <= 1'b0;
         r_xDir       <= 1'b0;
         r_yDir       <= 2'b00;
         r_rally      <= 8'd0;
         r_lives      <= LIVES_INIT;
         r_gameOver   <= 1'b0;
      end else begin
         r_ballEnable <= w_tick && (r_state == PLAY);
         r_ballReset  <= 1'b0;
         r_xDir       <= w_xNext;
         if (!w_xNext) begin
            r_yDir <= 2'b00;
         end else if (w_topHalf) begin
            r_yDir <= 2'b01;
         end else begin
            r_yDir <= 2'b10;
         end

         if (w_xNext && !r_xDir && (r_rally != 8'hFF)) begin
            r_rally <= r_rally + 8'd1;
         end

         case (r_state)
            IDLE, GAME_OVER: begin
               if (start) begin
                  r_state      <= SERVE;
                  r_serveCount <= '0;
                  r_ballReset  <= 1'b1;
                  r_lives      <= LIVES_INIT;
                  r_rally      <= 8'd0;
                  r_gameOver   <= 1'b0;
               end
            end
            SERVE: begin
               if (w_tick) begin
                  if (r_serveCount >= SERVE_LAST) begin
                     r_state      <= PLAY;
                     r_serveCount <= '0;
                  end else begin
                     r_serveCount <= r_serveCount + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (w_miss) begin
                  r_state <= MISS;
               end
            end
            MISS: begin
               r_lives     <= r_lives - 4'd1;
               r_ballReset <= 1'b1;
               if (r_lives == 4'd1) begin
                  r_state    <= GAME_OVER;
                  r_gameOver <= 1'b1;
               end else begin
                  r_state      <= SERVE;
                  r_serveCount <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ball_enable  = r_ballEnable;
   assign ball_reset   = r_ballReset;
   assign x_dir_change = r_xDir;
   assign y_dir_change = r_yDir;
   assign rally_count  = r_rally;
   assign lives        = r_lives;
   assign game_over    = r_gameOver;
   assign state        = r_state;

endmodule

// File: tb/tb_paddle_collision_ctrl.sv
// Self-checking bench for paddle_collision_ctrl: directed collision vectors
// plus hand-written serve, miss, game-over and async-reset sequences.
module tb_paddle_collision_ctrl;

   logic       clock;
   logic       reset;
   logic       start;
   logic [8:0] paddle_y;
   logic [7:0] ball_x;
   logic [8:0] ball_y;
   logic       ball_dir;
   logic       ball_enable;
   logic       ball_reset;
   logic       x_dir_change;
   logic [1:0] y_dir_change;
   logic [7:0] rally_count;
   logic [3:0] lives;
   logic       game_over;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   logic [1:0] modelCount;

   typedef struct {
      logic [8:0] paddleY;
      logic [7:0] ballX;
      logic [8:0] ballY;
      logic       ballDir;
      logic       expX;
      logic [1:0] expY;
      logic [7:0] expRally;
   } vec_t;

   vec_t vecs[16];

   paddle_collision_ctrl #(
      .TICK_DIV(4),
      .PADDLE_X(210),
      .MISS_X(225),
      .PADDLE_HEIGHT(40),
      .BALL_SIZE(4),
      .SERVE_DELAY(2),
      .LIVES(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .paddle_y(paddle_y),
      .ball_x(ball_x),
      .ball_y(ball_y),
      .ball_dir(ball_dir),
      .ball_enable(ball_enable),
      .ball_reset(ball_reset),
      .x_dir_change(x_dir_change),
      .y_dir_change(y_dir_change),
      .rally_count(rally_count),
      .lives(lives),
      .game_over(game_over),
      .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference frame divider: ticks whenever this reaches 3 (TICK_DIV=4).
   always @(posedge clock or posedge reset) begin
      if (reset) modelCount <= 2'd0;
      else       modelCount <= modelCount + 2'd1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [8:0] py, input logic [7:0] bx, input logic [8:0] by, input logic bd);
      @(negedge clock);
      paddle_y = py;
      ball_x   = bx;
      ball_y   = by;
      ball_dir = bd;
   endtask

   // Called at a negedge while in SERVE; follows the serve to PLAY.
   task automatic waitPlay(input int resetPulses);
      int ticks = 0;
      int enables = 0;
      int resets = resetPulses;
      int n = 0;
      while (state != 3'd2 && n < 100) begin
         if (modelCount == 2'd3) ticks++;
         if (ball_enable) enables++;
         @(negedge clock);
         if (ball_reset) resets++;
         n++;
      end
      checkOutput("reachPlay", state, 3'd2);
      checkOutput("serveTicks", ticks, 2);
      checkOutput("serveEnables", enables, 0);
      checkOutput("ballResetWidth", resets, 1);
   endtask

   task automatic startGame();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("startState", state, 3'd1);
      checkOutput("startBallReset", ball_reset, 1);
      checkOutput("startLives", lives, 3);
      checkOutput("startRally", rally_count, 0);
      checkOutput("startGameOver", game_over, 0);
      waitPlay(1);
   endtask

   task automatic doMiss(input logic [3:0] expLives, input logic [2:0] expState, input logic [7:0] expRally);
      applyStimulus(9'd200, 8'd225, 9'd100, 1'b1);
      @(negedge clock);
      checkOutput("missState", state, 3'd3);
      checkOutput("missBallResetEarly", ball_reset, 0);
      paddle_y = 9'd200;
      ball_x   = 8'd0;
      ball_dir = 1'b0;
      @(negedge clock);
      checkOutput("afterMissState", state, expState);
      checkOutput("afterMissLives", lives, expLives);
      checkOutput("afterMissBallReset", ball_reset, 1);
      checkOutput("afterMissRally", rally_count, expRally);
      if (expState == 3'd1) waitPlay(1);
   endtask

   initial begin
      int pulses;
      int firstAt;
      int secondAt;

      vecs[0]  = '{9'd200, 8'd212, 9'd205, 1'b1, 1'b1, 2'b01, 8'd1};
      vecs[1]  = '{9'd200, 8'd212, 9'd205, 1'b1, 1'b1, 2'b01, 8'd1};
      vecs[2]  = '{9'd200, 8'd212, 9'd230, 1'b1, 1'b1, 2'b10, 8'd1};
      vecs[3]  = '{9'd200, 8'd212, 9'd250, 1'b1, 1'b0, 2'b00, 8'd1};
      vecs[4]  = '{9'd200, 8'd212, 9'd205, 1'b0, 1'b0, 2'b00, 8'd1};
      vecs[5]  = '{9'd200, 8'd210, 9'd196, 1'b1, 1'b0, 2'b00, 8'd1};
      vecs[6]  = '{9'd200, 8'd210, 9'd197, 1'b1, 1'b1, 2'b01, 8'd2};
      vecs[7]  = '{9'd200, 8'd209, 9'd205, 1'b1, 1'b0, 2'b00, 8'd2};
      vecs[8]  = '{9'd200, 8'd224, 9'd239, 1'b1, 1'b1, 2'b10, 8'd3};
      vecs[9]  = '{9'd200, 8'd224, 9'd240, 1'b1, 1'b0, 2'b00, 8'd3};
      vecs[10] = '{9'd200, 8'd215, 9'd218, 1'b1, 1'b1, 2'b10, 8'd4};
      vecs[11] = '{9'd200, 8'd215, 9'd217, 1'b1, 1'b1, 2'b01, 8'd4};
      vecs[12] = '{9'd0,   8'd212, 9'd100, 1'b1, 1'b0, 2'b00, 8'd4};
      vecs[13] = '{9'd0,   8'd212, 9'd0,   1'b1, 1'b1, 2'b01, 8'd5};
      vecs[14] = '{9'd500, 8'd220, 9'd511, 1'b1, 1'b1, 2'b01, 8'd5};
      vecs[15] = '{9'd200, 8'd0,   9'd0,   1'b0, 1'b0, 2'b00, 8'd5};

      reset    = 1'b1;
      start    = 1'b0;
      paddle_y = 9'd200;
      ball_x   = 8'd0;
      ball_y   = 9'd0;
      ball_dir = 1'b0;
      #12;
      checkOutput("rstState", state, 3'd0);
      checkOutput("rstLives", lives, 3);
      checkOutput("rstRally", rally_count, 0);
      checkOutput("rstX", x_dir_change, 0);
      checkOutput("rstY", y_dir_change, 0);
      checkOutput("rstEnable", ball_enable, 0);
      checkOutput("rstBallReset", ball_reset, 0);
      checkOutput("rstGameOver", game_over, 0);
      @(negedge clock);
      reset = 1'b0;

      startGame();

      pulses   = 0;
      firstAt  = -1;
      secondAt = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         if (ball_enable) begin
            pulses++;
            if (firstAt < 0) firstAt = i;
            else if (secondAt < 0) secondAt = i;
         end
      end
      checkOutput("enablePulses", pulses, 4);
      checkOutput("enableGap", secondAt - firstAt, 4);

      @(negedge clock);
      start = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("startIgnoredState", state, 3'd2);
      checkOutput("startIgnoredBallReset", ball_reset, 0);
      start = 1'b0;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].paddleY, vecs[i].ballX, vecs[i].ballY, vecs[i].ballDir);
         @(negedge clock);
         checkOutput($sformatf("vec%0d_x", i), x_dir_change, vecs[i].expX);
         checkOutput($sformatf("vec%0d_y", i), y_dir_change, vecs[i].expY);
         checkOutput($sformatf("vec%0d_rally", i), rally_count, vecs[i].expRally);
      end

      for (int i = 0; i < 260; i++) begin
         applyStimulus(9'd200, 8'd212, 9'd205, 1'b1);
         applyStimulus(9'd200, 8'd0, 9'd0, 1'b0);
      end
      @(negedge clock);
      checkOutput("rallySaturate", rally_count, 255);
      checkOutput("rallyStillPlay", state, 3'd2);

      doMiss(4'd2, 3'd1, 8'd255);
      doMiss(4'd1, 3'd1, 8'd255);
      doMiss(4'd0, 3'd4, 8'd255);
      checkOutput("gameOverFlag", game_over, 1);

      applyStimulus(9'd200, 8'd212, 9'd205, 1'b1);
      repeat (2) @(negedge clock);
      checkOutput("gameOverX", x_dir_change, 0);
      checkOutput("gameOverY", y_dir_change, 0);
      checkOutput("gameOverHold", state, 3'd4);
      paddle_y = 9'd200;
      ball_x   = 8'd0;
      ball_dir = 1'b0;

      startGame();

      applyStimulus(9'd200, 8'd212, 9'd205, 1'b1);
      @(negedge clock);
      checkOutput("preResetX", x_dir_change, 1);
      checkOutput("preResetRally", rally_count, 1);

      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncState", state, 3'd0);
      checkOutput("asyncLives", lives, 3);
      checkOutput("asyncRally", rally_count, 0);
      checkOutput("asyncX", x_dir_change, 0);
      checkOutput("asyncY", y_dir_change, 0);
      checkOutput("asyncEnable", ball_enable, 0);
      checkOutput("asyncBallReset", ball_reset, 0);
      checkOutput("asyncGameOver", game_over, 0);
      @(negedge clock);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
